tcm_arbiter: RTL and testbench
==============================

// Module: tcm_arbiter
// PURPOSE
//  Two-master front end for the single-port TCM: arbitrates instruction-fetch and load/store requests onto one
//  TCM port. Formats data-side accesses (byte-enables, lane shift, load sign/zero extension) and flags misalignment.
//  Sits between the core's fetch/LSU stages and the TCM; one access outstanding at a time.
// PARAMETERS
//  MEM_ADDR_WIDTH  8  TCM word-address width; TCM holds 2**MEM_ADDR_WIDTH 32-bit words
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset_n      in   1   asynchronous, active-low reset
//  i_i_req        in   1   fetch request; held with address until o_i_ack
//  i_i_addr       in   32  fetch byte address; bits [1:0] ignored
//  o_i_ack        out  1   fetch complete, one-cycle pulse
//  o_i_data       out  32  fetched word, valid while o_i_ack
//  i_d_req        in   1   load/store request; held with fields until o_d_ack
//  i_d_addr       in   32  data byte address
//  i_d_we         in   1   1 = store, 0 = load
//  i_d_size       in   2   00 byte, 01 half, 10 word, 11 treated as word
//  i_d_unsigned   in   1   load zero-extends when 1, sign-extends when 0
//  i_d_wdata      in   32  store data, right-aligned
//  o_d_ack        out  1   data access complete, one-cycle pulse
//  o_d_err        out  1   misaligned access, valid with o_d_ack
//  o_d_rdata      out  32  extended load result, valid while o_d_ack (0 on store/error)
//  o_tcm_sel      out  1   TCM select
//  o_tcm_addr     out  MEM_ADDR_WIDTH  TCM word address (= byte address [MEM_ADDR_WIDTH+1:2])
//  o_tcm_write    out  4   TCM byte write enables
//  o_tcm_data     out  32  TCM write data, lane-shifted
//  i_tcm_ack      in   1   TCM ack, one cycle after o_tcm_sel
//  i_tcm_data     in   32  TCM read word, valid with i_tcm_ack
// BEHAVIOUR
//  - Reset: FSM IDLE, last-grant = fetch, all outputs 0. Async assert; deassert synchronous to i_clk by upstream.
//  - FSM: IDLE -> ACCESS -> WAIT -> (IDLE | ACCESS). TCM port outputs are registered.
//  - IDLE: if any request, pick winner, register addr/we/enables/shifted data; next state ACCESS.
//  - Arbitration: only one requester -> it wins. Both -> the master not granted last wins (round robin);
//    after reset data wins first. Last-grant updates on each grant.
//  - ACCESS: o_tcm_sel=1 for exactly this cycle, o_tcm_write = enables (0 for loads/fetch); next WAIT.
//  - WAIT: o_tcm_sel=0, o_tcm_write=0. On i_tcm_ack: owner ack=1 for this cycle, read data returned
//    combinationally from i_tcm_data. Same cycle: if the OTHER master requests, grant it -> ACCESS;
//    else IDLE. Acked master's req is ignored in its ack cycle (req&ack = handshake done).
//  - Latency: req sampled in IDLE at edge N -> o_tcm_sel during N+1 -> ack during N+2. Alternating
//    masters sustain one access per 2 cycles; same master one per 3 cycles.
//  - Byte enables (offset = addr[1:0]): byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
//    Write data: byte replicated to all lanes, half replicated to both halves, word as is.
//  - Load: byte lane = i_tcm_data[8*off+:8]; half lane = i_tcm_data[16*off[1]+:16]; extend to 32 per i_d_unsigned.
//  - Misalignment: half with addr[0]=1, word with addr[1:0]!=0. Detected in IDLE/grant; no TCM access issued,
//    FSM goes to ERR for one cycle: o_d_ack=1, o_d_err=1, o_d_rdata=0, then IDLE. Counts as a grant.
//  - Fetch never errors; addr[1:0] ignored. Address bits above MEM_ADDR_WIDTH+1 ignored (decode upstream).
//  - Stray i_tcm_ack in IDLE/ACCESS is ignored. o_*_ack never asserted without a prior grant.
//  - Reset mid-access: FSM to IDLE immediately, pending access dropped, no ack issued; late TCM ack ignored.
// TESTING
//  - Fetch only: i_i_req, addr 0x10 -> o_tcm_sel 1 cycle with addr 4, write 0; o_i_ack 2 cycles later, data = word 4.
//  - Stores: sb 0xA5 @0x21 -> write 4'b0010, data 0xA5A5A5A5; sh 0x1234 @0x22 -> 4'b1100; sw @0x20 -> 4'b1111.
//  - Loads of 0x80FF7F01 @0x20: lb off1 -> 0x0000007F; lb off3 -> 0xFFFFFF80; lhu off2 -> 0x000080FF; lh off2 -> 0xFFFF80FF.
//  - Both request continuously from reset: grants D,I,D,I...; each ack 2 cycles apart, no double-ack, no starvation.
//  - Misaligned lw @0x22 -> o_d_ack+o_d_err 1 cycle, o_tcm_sel never asserted, memory unchanged.
//  - Assert i_reset_n=0 in WAIT -> all outputs 0 at once, no ack after release; next request served normally.

Source files
------------

// File: rtl/tcm_arbiter.sv
// Two-master front end for the single-port TCM: round-robin arbitration between fetch and
// load/store, data-side lane formatting, load extension and misalignment detection.
module tcm_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_i_req,
  input  logic [31:0]               i_i_addr,
  output logic                      o_i_ack,
  output logic [31:0]               o_i_data,
  input  logic                      i_d_req,
  input  logic [31:0]               i_d_addr,
  input  logic                      i_d_we,
  input  logic [1:0]                i_d_size,
  input  logic                      i_d_unsigned,
  input  logic [31:0]               i_d_wdata,
  output logic                      o_d_ack,
  output logic                      o_d_err,
  output logic [31:0]               o_d_rdata,
  output logic                      o_tcm_sel,
  output logic [MEM_ADDR_WIDTH-1:0] o_tcm_addr,
  output logic [3:0]                o_tcm_write,
  output logic [31:0]               o_tcm_data,
  input  logic                      i_tcm_ack,
  input  logic [31:0]               i_tcm_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StErr} state_e;

  state_e                    state_q, state_d;
  logic                      last_d_q, last_d_d;   // last grant went to the data side
  logic                      owner_q, owner_d;     // current access belongs to the data side
  logic                      tcm_sel_q, tcm_sel_d;
  logic [MEM_ADDR_WIDTH-1:0] tcm_addr_q, tcm_addr_d;
  logic [3:0]                tcm_write_q, tcm_write_d;
  logic [31:0]               tcm_data_q, tcm_data_d;
  logic                      ld_we_q, ld_we_d;
  logic [1:0]                ld_size_q, ld_size_d;
  logic                      ld_uns_q, ld_uns_d;
  logic [1:0]                ld_off_q, ld_off_d;

  logic [1:0]  d_off;
  logic        d_misaligned;
  logic [3:0]  d_be;
  logic [31:0] d_wdata_lanes;
  logic        ack_cycle;
  logic        grant, pick_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Address bits outside the TCM window and fetch byte offset are decoded elsewhere
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_i_addr[31:MEM_ADDR_WIDTH+2], i_i_addr[1:0],
                              i_d_addr[31:MEM_ADDR_WIDTH+2]};

  assign d_off     = i_d_addr[1:0];
  assign ack_cycle = (state_q == StWait) && i_tcm_ack;

  always_comb begin
    case (i_d_size)
      2'b00: begin
        d_be          = 4'b0001 << d_off;
        d_wdata_lanes = {4{i_d_wdata[7:0]}};
        d_misaligned  = 1'b0;
      end
      2'b01: begin
        d_be          = 4'b0011 << d_off;
        d_wdata_lanes = {2{i_d_wdata[15:0]}};
        d_misaligned  = d_off[0];
      end
      default: begin
        d_be          = 4'b1111;
        d_wdata_lanes = i_d_wdata;
        d_misaligned  = |d_off;
      end
    endcase
  end

  // In the ack cycle only the other master may be granted; the acked request is finished
  always_comb begin
    grant  = 1'b0;
    pick_d = 1'b0;
    if (state_q == StIdle) begin
      grant  = i_i_req | i_d_req;
      pick_d = i_d_req & (~i_i_req | ~last_d_q);
    end else if (ack_cycle) begin
      grant  = owner_q ? i_i_req : i_d_req;
      pick_d = ~owner_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    owner_d     = owner_q;
    tcm_sel_d   = 1'b0;
    tcm_write_d = 4'b0000;
    tcm_addr_d  = tcm_addr_q;
    tcm_data_d  = tcm_data_q;
    ld_we_d     = ld_we_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    ld_off_d    = ld_off_q;

    case (state_q)
      StAccess: state_d = StWait;
      StWait:   if (i_tcm_ack) state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = state_q;
    endcase

    if (grant) begin
      last_d_d = pick_d;
      owner_d  = pick_d;
      if (pick_d && d_misaligned) begin
        state_d = StErr;
      end else begin
        state_d   = StAccess;
        tcm_sel_d = 1'b1;
        if (pick_d) begin
          tcm_addr_d  = i_d_addr[MEM_ADDR_WIDTH+1:2];
          tcm_write_d = i_d_we ? d_be : 4'b0000;
          tcm_data_d  = i_d_we ? d_wdata_lanes : 32'd0;
          ld_we_d     = i_d_we;
          ld_size_d   = i_d_size;
          ld_uns_d    = i_d_unsigned;
          ld_off_d    = d_off;
        end else begin
          tcm_addr_d = i_i_addr[MEM_ADDR_WIDTH+1:2];
          tcm_data_d = 32'd0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      owner_q     <= 1'b0;
      tcm_sel_q   <= 1'b0;
      tcm_addr_q  <= '0;
      tcm_write_q <= 4'b0000;
      tcm_data_q  <= 32'd0;
      ld_we_q     <= 1'b0;
      ld_size_q   <= 2'b00;
      ld_uns_q    <= 1'b0;
      ld_off_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      owner_q     <= owner_d;
      tcm_sel_q   <= tcm_sel_d;
      tcm_addr_q  <= tcm_addr_d;
      tcm_write_q <= tcm_write_d;
      tcm_data_q  <= tcm_data_d;
      ld_we_q     <= ld_we_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      ld_off_q    <= ld_off_d;
    end
  end

  always_comb begin
    case (ld_off_q)
      2'd0:    ld_byte = i_tcm_data[7:0];
      2'd1:    ld_byte = i_tcm_data[15:8];
      2'd2:    ld_byte = i_tcm_data[23:16];
      default: ld_byte = i_tcm_data[31:24];
    endcase
    ld_half = ld_off_q[1] ? i_tcm_data[31:16] : i_tcm_data[15:0];
    case (ld_size_q)
      2'b00:   ld_ext = {{24{~ld_uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~ld_uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = i_tcm_data;
    endcase
  end

  assign o_i_ack     = ack_cycle & ~owner_q;
  assign o_i_data    = o_i_ack ? i_tcm_data : 32'd0;
  assign o_d_err     = (state_q == StErr);
  assign o_d_ack     = (ack_cycle & owner_q) | o_d_err;
  assign o_d_rdata   = (ack_cycle && owner_q && !ld_we_q) ? ld_ext : 32'd0;
  assign o_tcm_sel   = tcm_sel_q;
  assign o_tcm_addr  = tcm_addr_q;
  assign o_tcm_write = tcm_write_q;
  assign o_tcm_data  = tcm_data_q;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Self-checking bench for tcm_arbiter: byte-addressed reference memory, directed and
// randomized accesses, arbitration and reset-abort scenarios.
module tb_tcm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_uns = 1'b0;
  logic [31:0] d_wdata = '0;
  logic        i_ack, d_ack, d_err, tcm_sel;
  logic [31:0] i_data, d_rdata, tcm_data;
  logic [7:0]  tcm_addr;
  logic [3:0]  tcm_write;
  bit          tcm_ack;
  logic [31:0] tcm_rdata;

  int n_run = 0;
  int n_fail = 0;

  tcm_arbiter #(.MEM_ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_data(i_data),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we(d_we), .i_d_size(d_size),
    .i_d_unsigned(d_uns), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_err(d_err), .o_d_rdata(d_rdata),
    .o_tcm_sel(tcm_sel), .o_tcm_addr(tcm_addr), .o_tcm_write(tcm_write), .o_tcm_data(tcm_data),
    .i_tcm_ack(tcm_ack), .i_tcm_data(tcm_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b ^ 8'h5A, ~b, b + 8'h33, b ^ 8'hC3};
  endfunction

  // TCM model: not tied to the DUT reset, so a pending ack still arrives after an abort
  bit          mem_ready;
  logic [31:0] tcm_mem [0:255];
  logic [31:0] wr_word;
  always_comb begin
    wr_word = tcm_mem[tcm_addr];
    for (int k = 0; k < 4; k++) if (tcm_write[k]) wr_word[8*k+:8] = tcm_data[8*k+:8];
  end
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 256; k++) tcm_mem[k] <= init_word(k);
      mem_ready <= 1'b1;
    end else if (tcm_sel) begin
      tcm_mem[tcm_addr] <= wr_word;
    end
    tcm_ack   <= tcm_sel;
    tcm_rdata <= tcm_sel ? tcm_mem[tcm_addr] : $urandom;
  end

  // Reference model: flat little-endian byte memory
  logic [7:0] ref_b [0:1023];

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int n, input bit uns);
    longint v;
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_b[a+k]) << (8*k);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic ref_store(input int a, input int n, input logic [31:0] wdata);
    for (int k = 0; k < n; k++) ref_b[a+k] = 8'((wdata >> (8*k)) & 32'hFF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fetch_op(input logic [31:0] addr, output logic [31:0] data, output int sel_at,
                          output int ack_at, output logic [7:0] a_seen,
                          output logic [3:0] w_seen);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr;
    sel_at = -1; ack_at = -1; data = '0; a_seen = '0; w_seen = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tcm_sel && sel_at < 0) begin sel_at = c; a_seen = tcm_addr; w_seen = tcm_write; end
      if (i_ack) begin ack_at = c; data = i_data; break; end
    end
    i_req = 1'b0;
  endtask

  task automatic data_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int sel_cnt,
                         output int ack_at, output logic [3:0] w_seen,
                         output logic [31:0] wd_seen);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wdata;
    sel_cnt = 0; ack_at = -1; rdata = '0; err = 1'b0; w_seen = '0; wd_seen = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tcm_sel) begin sel_cnt++; w_seen = tcm_write; wd_seen = tcm_data; end
      if (d_ack) begin ack_at = c; rdata = d_rdata; err = d_err; break; end
    end
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_run++;
    if ({i_ack, d_ack, d_err, tcm_sel, tcm_write, tcm_addr, tcm_data, i_data, d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero (sel=%b write=%b addr=%h), need all 0",
                         tcm_sel, tcm_write, tcm_addr);
    end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++;
      if ({i_ack, d_ack, tcm_sel} !== 3'b000) begin
        n_fail++; $display("FAIL idle_quiet: acks/sel=%b, need 000", {i_ack, d_ack, tcm_sel});
      end
    end
  endtask

  task automatic test_fetch();
    logic [31:0] data; int sel_at, ack_at; logic [7:0] a; logic [3:0] w;
    fetch_op(32'h10, data, sel_at, ack_at, a, w);
    n_run++;
    if (sel_at !== 1 || ack_at !== 2) begin
      n_fail++; $display("FAIL fetch_latency: sel at %0d ack at %0d, need 1 and 2", sel_at, ack_at);
    end
    n_run++;
    if (a !== 8'd4 || w !== 4'b0000) begin
      n_fail++; $display("FAIL fetch_port: addr=%h write=%b, need 04 0000", a, w);
    end
    n_run++;
    if (data !== ref_load(32'h10, 4, 1'b1)) begin
      n_fail++; $display("FAIL fetch_data: got %h need %h", data, ref_load(32'h10, 4, 1'b1));
    end
  endtask

  task automatic test_store();
    logic [31:0] r, wd; logic e; int sc, aa; logic [3:0] w;
    logic [31:0] addrs [3]; logic [1:0] sizes [3]; logic [31:0] wdat [3];
    logic [3:0] exp_w [3]; logic [31:0] exp_wd [3];
    addrs = '{32'h21, 32'h22, 32'h20};
    sizes = '{2'd0, 2'd1, 2'd2};
    wdat  = '{32'h0000_00A5, 32'h0000_1234, 32'h80FF_7F01};
    exp_w = '{4'b0010, 4'b1100, 4'b1111};
    exp_wd = '{32'hA5A5_A5A5, 32'h1234_1234, 32'h80FF_7F01};
    for (int t = 0; t < 3; t++) begin
      data_op(1'b1, sizes[t], 1'b0, addrs[t], wdat[t], r, e, sc, aa, w, wd);
      ref_store(int'(addrs[t]), nbytes(sizes[t]), wdat[t]);
      n_run++;
      if (w !== exp_w[t] || wd !== exp_wd[t] || sc !== 1) begin
        n_fail++; $display("FAIL store_%0d: write=%b data=%h sels=%0d, need %b %h 1",
                           t, w, wd, sc, exp_w[t], exp_wd[t]);
      end
      n_run++;
      if (e !== 1'b0 || r !== 32'd0 || aa !== 2) begin
        n_fail++; $display("FAIL store_ack_%0d: err=%b rdata=%h ack at %0d, need 0 0 2",
                           t, e, r, aa);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] r, wd; logic e; int sc, aa; logic [3:0] w;
    logic [31:0] addrs [4]; logic [1:0] sizes [4]; logic unss [4]; logic [31:0] exp [4];
    addrs = '{32'h21, 32'h23, 32'h22, 32'h22};
    sizes = '{2'd0, 2'd0, 2'd1, 2'd1};
    unss  = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp   = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF};
    for (int t = 0; t < 4; t++) begin
      data_op(1'b0, sizes[t], unss[t], addrs[t], 32'hFFFF_FFFF, r, e, sc, aa, w, wd);
      n_run++;
      if (r !== exp[t] || e !== 1'b0 || w !== 4'b0000) begin
        n_fail++; $display("FAIL load_%0d: rdata=%h err=%b write=%b, need %h 0 0000",
                           t, r, e, w, exp[t]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] r, wd; logic e; int sc, aa; logic [3:0] w;
    data_op(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, r, e, sc, aa, w, wd);
    n_run++;
    if (e !== 1'b1 || r !== 32'd0 || sc !== 0 || aa !== 1) begin
      n_fail++; $display("FAIL misalign_lw: err=%b rdata=%h sels=%0d ack at %0d, need 1 0 0 1",
                         e, r, sc, aa);
    end
    data_op(1'b1, 2'd1, 1'b0, 32'h21, 32'h5555, r, e, sc, aa, w, wd);
    n_run++;
    if (e !== 1'b1 || sc !== 0) begin
      n_fail++; $display("FAIL misalign_sh: err=%b sels=%0d, need 1 0", e, sc);
    end
    data_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, e, sc, aa, w, wd);
    n_run++;
    if (r !== 32'h80FF_7F01 || e !== 1'b0) begin
      n_fail++; $display("FAIL misalign_mem_unchanged: got %h err=%b, need 80ff7f01 0", r, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, wd, addr, wdata, exp_r; logic e, we, uns; int sc, aa, a, n, off;
    logic [1:0] size; logic [3:0] w, exp_w; bit mis, lanes_ok;
    for (int t = 0; t < 40; t++) begin
      addr = $urandom; size = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1)); wdata = $urandom;
      a = int'(addr[9:0]); n = nbytes(size); off = a % 4; mis = (a % n) != 0;
      exp_w = '0;
      if (we && !mis) for (int k = 0; k < n; k++) exp_w[off+k] = 1'b1;
      exp_r = (mis || we) ? 32'd0 : ref_load(a, n, uns);
      data_op(we, size, uns, addr, wdata, r, e, sc, aa, w, wd);
      if (we && !mis) ref_store(a, n, wdata);
      n_run++;
      if (e !== 1'(mis) || sc !== (mis ? 0 : 1) || aa !== (mis ? 1 : 2)) begin
        n_fail++; $display("FAIL rand_ctl_%0d: err=%b sels=%0d ack at %0d (addr %h size %0d)",
                           t, e, sc, aa, addr, size);
      end
      n_run++;
      if (r !== exp_r || w !== exp_w) begin
        n_fail++; $display("FAIL rand_data_%0d: rdata=%h write=%b, need %h %b", t, r, w,
                           exp_r, exp_w);
      end
      if (we && !mis) begin
        lanes_ok = 1'b1;
        for (int k = 0; k < n; k++)
          if (wd[8*(off+k)+:8] !== wdata[8*k+:8]) lanes_ok = 1'b0;
        n_run++;
        if (!lanes_ok) begin
          n_fail++; $display("FAIL rand_lanes_%0d: tcm data %h for wdata %h at off %0d",
                             t, wd, wdata, off);
        end
      end
    end
    for (int t = 0; t < 8; t++) begin
      logic [31:0] data; int sa, ka; logic [7:0] fa; logic [3:0] fw;
      addr = $urandom;
      fetch_op(addr, data, sa, ka, fa, fw);
      n_run++;
      if (data !== ref_load(int'(addr[9:2]) * 4, 4, 1'b1) || ka !== 2 || fw !== 4'b0000) begin
        n_fail++; $display("FAIL rand_fetch_%0d: data=%h ack at %0d write=%b, need %h 2 0000",
                           t, data, ka, fw, ref_load(int'(addr[9:2]) * 4, 4, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0, last_c = 0; bit last_d = 1'b0, cur_d;
    logic [31:0] exp_d, exp_i;
    exp_d = ref_load(32'h40, 4, 1'b1);
    exp_i = ref_load(32'h80, 4, 1'b1);
    do_reset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_uns = 1'b0; d_addr = 32'h40;
    i_req = 1'b1; i_addr = 32'h80;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) begin
        n_run++; n_fail++; $display("FAIL b2b_double_ack: both acks at cycle %0d", c);
      end else if (i_ack || d_ack) begin
        cur_d = d_ack;
        n_run++;
        if (n_ack == 0 ? (cur_d !== 1'b1) : (cur_d === last_d || c - last_c != 2)) begin
          n_fail++; $display("FAIL b2b_order: ack %0d data=%b gap %0d, need alternate gap 2",
                             n_ack, cur_d, c - last_c);
        end
        n_run++;
        if ((cur_d ? d_rdata : i_data) !== (cur_d ? exp_d : exp_i)) begin
          n_fail++; $display("FAIL b2b_data: got %h need %h", cur_d ? d_rdata : i_data,
                             cur_d ? exp_d : exp_i);
        end
        last_d = cur_d; last_c = c; n_ack++;
      end
    end
    n_run++;
    if (n_ack < 10) begin
      n_fail++; $display("FAIL b2b_throughput: %0d acks in 24 cycles, need at least 10", n_ack);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int found = 0;
    logic [31:0] data; int sa, ka; logic [7:0] fa; logic [3:0] fw;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h30;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (tcm_sel) found = 1;
    end
    n_run++;
    if (found == 0) begin
      n_fail++; $display("FAIL reset_mid_sel: tcm select 0 within 10 cycles, need 1");
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_run++;
    if ({i_ack, d_ack, d_err, tcm_sel, tcm_write, tcm_addr, tcm_data, i_data, d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: i_ack=%b sel=%b addr=%h, need all 0",
                         i_ack, tcm_sel, tcm_addr);
    end
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_run++;
      if ({i_ack, d_ack} !== 2'b00) begin
        n_fail++; $display("FAIL reset_mid_late_ack: acks=%b, need 00", {i_ack, d_ack});
      end
    end
    fetch_op(32'h30, data, sa, ka, fa, fw);
    n_run++;
    if (data !== ref_load(32'h30, 4, 1'b1) || ka !== 2) begin
      n_fail++; $display("FAIL reset_mid_recover: data=%h ack at %0d, need %h 2", data, ka,
                         ref_load(32'h30, 4, 1'b1));
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k+:8];
    end
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_misalign();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "timeout");
  end

endmodule
